// File: rtl/trace_pkg.sv
// Shared types for the address trace encoder and anything that reads its records.
package trace_pkg;

  localparam int ADDR_W = 31;
  localparam int REC_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // One trace record: the first record of a run carries the absolute address.
  typedef struct packed {
    logic              first;
    logic [ADDR_W-1:0] delta;
  } trace_rec_t;

endpackage

// File: rtl/addr_trace_encoder_if.sv
// Address input stream and record output stream of the trace encoder.
interface addr_trace_encoder_if;
  import trace_pkg::*;

  logic              addr_valid_41;
  logic              addr_ready_41;
  logic [ADDR_W-1:0] addr_41;
  logic              delta_valid_41;
  logic              delta_ready_41;
  logic [ADDR_W-1:0] delta_41;
  logic              first_41;

  // Address producer and record consumer side.
  modport master (
    output addr_valid_41, addr_41, delta_ready_41,
    input  addr_ready_41, delta_valid_41, delta_41, first_41
  );

  // Encoder side.
  modport slave (
    input  addr_valid_41, addr_41, delta_ready_41,
    output addr_ready_41, delta_valid_41, delta_41, first_41
  );

endinterface

// File: rtl/trace_fifo.sv
// Synchronous FIFO with a registered head word; a write into an empty FIFO
// shows up on the head one cycle later, and the head holds when empty.
module trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE_LVL  = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] rd_next;
  logic [PTR_W:0]   level_q;
  logic [WIDTH-1:0] head_q;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = head_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rd_next = rd_ptr_q + PTR_W'(1);

  // Storage array; contents need no reset because level_q gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // Pointers, occupancy and the registered head word.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_next;
      end
      if (push_ok && !pop_ok) begin
        level_q <= level_q + ONE_LVL;
      end else if (!push_ok && pop_ok) begin
        level_q <= level_q - ONE_LVL;
      end
      if (pop_ok && (level_q > ONE_LVL)) begin
        head_q <= mem_q[rd_next];
      end else if (push_ok && (empty_o || (pop_ok && (level_q == ONE_LVL)))) begin
        head_q <= data_i;
      end
    end
  end

endmodule

// File: rtl/addr_trace_encoder.sv
// Turns a stream of absolute addresses into delta records: the first record
// of a run is the absolute address, later ones are the wrapped difference
// from the previous address. Records queue in a small FIFO for the writer.
module addr_trace_encoder
  import trace_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int MAX_SAMPLES = 1500000
) (
  input  logic              clk_41,
  input  logic              rst_41,
  input  logic              start_41,
  addr_trace_encoder_if.slave bus,
  output logic [ADDR_W-1:0] count_41,
  output logic              busy_41,
  output logic              done_41
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] MAX_CNT  = ADDR_W'(MAX_SAMPLES);
  localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0]  ONE_LVL  = LVL_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] prev_addr_q, prev_addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic              first_q, first_d;
  logic              addr_ready_q, addr_ready_d;

  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_level;
  logic [LVL_W-1:0]  level_next;
  trace_rec_t        push_rec;
  trace_rec_t        head_rec;

  assign accept   = bus.addr_valid_41 && addr_ready_q && !fifo_full && (state_q == RUN);
  assign pop      = bus.delta_ready_41 && !fifo_empty;
  assign push_rec = '{first: first_q, delta: bus.addr_41 - prev_addr_q};

  trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_41),
    .rst_ni  (rst_41),
    .push_i  (accept),
    .data_i  (push_rec),
    .pop_i   (pop),
    .head_o  (head_rec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Next state, run bookkeeping, and the registered ready that looks one
  // edge ahead at the FIFO occupancy so it never depends on delta_ready.
  always_comb begin
    state_d     = state_q;
    prev_addr_d = prev_addr_q;
    count_d     = count_q;
    first_d     = first_q;
    level_next  = fifo_level;

    if (accept && !pop) begin
      level_next = fifo_level + ONE_LVL;
    end else if (!accept && pop) begin
      level_next = fifo_level - ONE_LVL;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_41) begin
          state_d     = RUN;
          prev_addr_d = '0;
          count_d     = '0;
          first_d     = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          prev_addr_d = bus.addr_41;
          count_d     = count_q + ADDR_W'(1);
          first_d     = 1'b0;
          if (count_d == MAX_CNT) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    addr_ready_d = (state_d == RUN) && (level_next != FULL_LVL);
  end

  // State and run registers with synchronous active-low reset.
  always_ff @(posedge clk_41) begin
    if (!rst_41) begin
      state_q      <= IDLE;
      prev_addr_q  <= '0;
      count_q      <= '0;
      first_q      <= 1'b0;
      addr_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_addr_q  <= prev_addr_d;
      count_q      <= count_d;
      first_q      <= first_d;
      addr_ready_q <= addr_ready_d;
    end
  end

  assign bus.addr_ready_41  = addr_ready_q;
  assign bus.delta_valid_41 = !fifo_empty;
  assign bus.delta_41       = head_rec.delta;
  assign bus.first_41       = head_rec.first;
  assign count_41           = count_q;
  assign busy_41            = (state_q == RUN) || (state_q == DRAIN);
  assign done_41            = (state_q == DONE);

endmodule

// File: tb/tb_addr_trace_encoder.sv
// Bench for addr_trace_encoder: a long-run instance (MAX_SAMPLES=10000) and a
// short-run instance (MAX_SAMPLES=3), checked by a queue scoreboard and an
// accumulating decoder that must reproduce the offered addresses.
module tb_addr_trace_encoder;
  import trace_pkg::*;

  logic clk_41;
  logic rst_41;
  logic startA, startB;
  logic [ADDR_W-1:0] countA, countB;
  logic busyA, busyB, doneA, doneB;

  addr_trace_encoder_if busA ();
  addr_trace_encoder_if busB ();

  addr_trace_encoder #(.DEPTH(4), .MAX_SAMPLES(10000)) dutA (
    .clk_41   (clk_41),
    .rst_41   (rst_41),
    .start_41 (startA),
    .bus      (busA),
    .count_41 (countA),
    .busy_41  (busyA),
    .done_41  (doneA)
  );

  addr_trace_encoder #(.DEPTH(4), .MAX_SAMPLES(3)) dutB (
    .clk_41   (clk_41),
    .rst_41   (rst_41),
    .start_41 (startB),
    .bus      (busB),
    .count_41 (countB),
    .busy_41  (busyB),
    .done_41  (doneB)
  );

  int checks = 0;
  int errors = 0;
  int readyModeA = 0;
  int readyModeB = 0;
  int occCheck = -1;

  // Scoreboard: expected records and the addresses a decoder must rebuild.
  trace_rec_t        expRecA[$];
  trace_rec_t        expRecB[$];
  logic [ADDR_W-1:0] expAddrA[$];
  logic [ADDR_W-1:0] expAddrB[$];
  logic [ADDR_W-1:0] pendingQ[$];

  // Reference model of the run: previous address, first flag, count.
  logic [ADDR_W-1:0] modelPrev[2];
  bit                modelFirst[2];
  int                modelCount[2];
  logic [ADDR_W-1:0] decAcc[2];

  // Free-running clock.
  initial clk_41 = 1'b0;
  always #5 clk_41 = ~clk_41;

  // Consumer readiness: 0 stalled, 1 always ready, 2 random.
  always @(posedge clk_41) begin
    #2;
    busA.delta_ready_41 = (readyModeA == 2) ? 1'($urandom_range(0, 1)) : (readyModeA == 1);
    busB.delta_ready_41 = (readyModeB == 2) ? 1'($urandom_range(0, 1)) : (readyModeB == 1);
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic waitCycle();
    @(posedge clk_41);
    #1;
  endtask

  function automatic int expQueueSize(input int which);
    return (which == 0) ? expRecA.size() : expRecB.size();
  endfunction

  function automatic logic getAddrReady(input int which);
    return (which == 0) ? busA.addr_ready_41 : busB.addr_ready_41;
  endfunction

  function automatic logic getDone(input int which);
    return (which == 0) ? doneA : doneB;
  endfunction

  task automatic setOffer(input int which, input logic v, input logic [ADDR_W-1:0] a);
    if (which == 0) begin
      busA.addr_valid_41 = v;
      busA.addr_41 = a;
    end else begin
      busB.addr_valid_41 = v;
      busB.addr_41 = a;
    end
  endtask

  task automatic armModel(input int which);
    modelFirst[which] = 1'b1;
    modelPrev[which]  = '0;
    modelCount[which] = 0;
  endtask

  task automatic clearModel(input int which);
    if (which == 0) begin
      expRecA.delete();
      expAddrA.delete();
    end else begin
      expRecB.delete();
      expAddrB.delete();
    end
    modelFirst[which] = 1'b0;
    modelPrev[which]  = '0;
    modelCount[which] = 0;
    decAcc[which]     = '0;
  endtask

  // Expected record for an accepted address: absolute first, then wrapped delta.
  task automatic pushExpected(input int which, input logic [ADDR_W-1:0] a);
    trace_rec_t r;
    r.first = modelFirst[which];
    r.delta = modelFirst[which] ? a : a - modelPrev[which];
    modelPrev[which]  = a;
    modelFirst[which] = 1'b0;
    modelCount[which]++;
    if (which == 0) begin
      expRecA.push_back(r);
      expAddrA.push_back(a);
    end else begin
      expRecB.push_back(r);
      expAddrB.push_back(a);
    end
  endtask

  // Compare a delivered record with the scoreboard and decode it.
  task automatic retireRecord(input int which, input trace_rec_t got);
    trace_rec_t        exp;
    logic [ADDR_W-1:0] expAddr;
    logic [ADDR_W-1:0] dec;
    if (expQueueSize(which) == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected record dut%0d: got delta %0d first %0d expected none", which, got.delta, got.first);
    end else begin
      if (which == 0) begin
        exp = expRecA.pop_front();
        expAddr = expAddrA.pop_front();
      end else begin
        exp = expRecB.pop_front();
        expAddr = expAddrB.pop_front();
      end
      checkOutput($sformatf("first flag dut%0d", which), got.first, exp.first);
      checkOutput($sformatf("delta dut%0d", which), got.delta, exp.delta);
      dec = got.first ? got.delta : decAcc[which] + got.delta;
      decAcc[which] = dec;
      checkOutput($sformatf("decoded addr dut%0d", which), dec, expAddr);
    end
  endtask

  // Monitors: a record leaves the DUT on the edge after valid and ready are seen.
  always @(negedge clk_41) begin
    trace_rec_t r;
    if (rst_41 && busA.delta_valid_41 && busA.delta_ready_41) begin
      r.first = busA.first_41;
      r.delta = busA.delta_41;
      retireRecord(0, r);
    end
    if (rst_41 && busB.delta_valid_41 && busB.delta_ready_41) begin
      r.first = busB.first_41;
      r.delta = busB.delta_41;
      retireRecord(1, r);
    end
  end

  // Offer every address in pendingQ back to back, bounded by a cycle budget.
  task automatic applyStimulus(input int which, input int budget, output int accepted);
    int cyc;
    accepted = 0;
    cyc = 0;
    while (pendingQ.size() > 0 && cyc < budget) begin
      setOffer(which, 1'b1, pendingQ[0]);
      @(negedge clk_41);
      if (getAddrReady(which)) begin
        pushExpected(which, pendingQ[0]);
        void'(pendingQ.pop_front());
        accepted++;
      end
      waitCycle();
      cyc++;
      if (occCheck >= 0) checkOutput("occupancy", expQueueSize(which), occCheck);
    end
    setOffer(which, 1'b0, '0);
    pendingQ.delete();
  endtask

  task automatic fillRandom(input int n);
    for (int i = 0; i < n; i++) pendingQ.push_back(ADDR_W'($urandom()));
  endtask

  task automatic pulseStart(input int which);
    if (which == 0) startA = 1'b1; else startB = 1'b1;
    waitCycle();
    startA = 1'b0;
    startB = 1'b0;
  endtask

  task automatic waitDrain(input int which, input int budget);
    int cyc = 0;
    while (expQueueSize(which) > 0 && cyc < budget) begin
      waitCycle();
      cyc++;
    end
    checkOutput($sformatf("drain dut%0d", which), expQueueSize(which), 0);
  endtask

  task automatic waitDone(input int which, input int budget);
    int cyc = 0;
    while (!getDone(which) && cyc < budget) begin
      waitCycle();
      cyc++;
    end
    @(negedge clk_41);
    checkOutput($sformatf("done dut%0d", which), getDone(which), 1);
    waitCycle();
  endtask

  task automatic checkResetA();
    @(negedge clk_41);
    checkOutput("reset addr_ready", busA.addr_ready_41, 0);
    checkOutput("reset delta_valid", busA.delta_valid_41, 0);
    checkOutput("reset first", busA.first_41, 0);
    checkOutput("reset delta", busA.delta_41, 0);
    checkOutput("reset count", countA, 0);
    checkOutput("reset busy", busyA, 0);
    checkOutput("reset done", doneA, 0);
    checkOutput("reset done dut1", doneB, 0);
    waitCycle();
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    logic [ADDR_W-1:0] basicAddrs[5];
    basicAddrs = '{31'd100, 31'd104, 31'd96, 31'd2147483647, 31'd0};

    rst_41 = 1'b0;
    startA = 1'b0;
    startB = 1'b0;
    setOffer(0, 1'b0, '0);
    setOffer(1, 1'b0, '0);
    clearModel(0);
    clearModel(1);
    repeat (3) waitCycle();
    checkResetA();
    rst_41 = 1'b1;
    waitCycle();

    // Terminal count on the short-run instance, then re-arm.
    readyModeB = 1;
    pulseStart(1);
    armModel(1);
    fillRandom(5);
    applyStimulus(1, 15, acc);
    checkOutput("terminal accepted", acc, 3);
    waitDrain(1, 20);
    waitDone(1, 20);
    @(negedge clk_41);
    checkOutput("terminal count", countB, 3);
    checkOutput("terminal busy", busyB, 0);
    waitCycle();
    pulseStart(1);
    armModel(1);
    @(negedge clk_41);
    checkOutput("rearm count", countB, 0);
    checkOutput("rearm busy", busyB, 1);
    checkOutput("rearm done", doneB, 0);
    waitCycle();
    fillRandom(1);
    applyStimulus(1, 5, acc);
    checkOutput("rearm accepted", acc, 1);
    waitDrain(1, 20);

    // Basic encode with the consumer always ready.
    readyModeA = 1;
    pulseStart(0);
    armModel(0);
    @(negedge clk_41);
    checkOutput("ready after start", busA.addr_ready_41, 1);
    checkOutput("busy after start", busyA, 1);
    waitCycle();
    setOffer(0, 1'b1, basicAddrs[0]);
    @(negedge clk_41);
    checkOutput("ready for first addr", busA.addr_ready_41, 1);
    if (busA.addr_ready_41) pushExpected(0, basicAddrs[0]);
    waitCycle();
    setOffer(0, 1'b0, '0);
    @(negedge clk_41);
    checkOutput("latency valid", busA.delta_valid_41, 1);
    waitCycle();
    for (int i = 1; i < 5; i++) pendingQ.push_back(basicAddrs[i]);
    applyStimulus(0, 20, acc);
    checkOutput("basic accepted", acc, 4);
    waitDrain(0, 20);
    @(negedge clk_41);
    checkOutput("basic count", countA, 5);
    waitCycle();

    // Backpressure: stalled consumer, addresses offered every cycle.
    readyModeA = 0;
    fillRandom(8);
    applyStimulus(0, 12, acc);
    checkOutput("backpressure accepted", acc, 4);
    readyModeA = 1;
    @(negedge clk_41);
    checkOutput("full ready low", busA.addr_ready_41, 0);
    waitCycle();
    @(negedge clk_41);
    checkOutput("ready after pop", busA.addr_ready_41, 1);
    waitCycle();
    waitDrain(0, 20);

    // start is ignored while running.
    pulseStart(0);
    @(negedge clk_41);
    checkOutput("count after ignored start", countA, modelCount[0]);
    checkOutput("busy after ignored start", busyA, 1);
    waitCycle();

    // Simultaneous push and pop at occupancy 2.
    readyModeA = 0;
    fillRandom(2);
    applyStimulus(0, 4, acc);
    checkOutput("prefill accepted", acc, 2);
    readyModeA = 1;
    occCheck = 2;
    fillRandom(20);
    applyStimulus(0, 40, acc);
    occCheck = -1;
    checkOutput("streaming accepted", acc, 20);
    waitDrain(0, 20);

    // Reset with three records buffered.
    readyModeA = 0;
    fillRandom(3);
    applyStimulus(0, 6, acc);
    checkOutput("pre-reset accepted", acc, 3);
    rst_41 = 1'b0;
    clearModel(0);
    clearModel(1);
    waitCycle();
    rst_41 = 1'b1;
    checkResetA();
    readyModeA = 1;
    repeat (3) waitCycle();
    @(negedge clk_41);
    checkOutput("no stale record", busA.delta_valid_41, 0);
    waitCycle();

    // Round trip of 10000 random addresses with a random consumer.
    pulseStart(0);
    armModel(0);
    readyModeA = 2;
    fillRandom(10000);
    applyStimulus(0, 40000, acc);
    checkOutput("roundtrip accepted", acc, 10000);
    @(negedge clk_41);
    checkOutput("ready at max", busA.addr_ready_41, 0);
    checkOutput("busy at max", busyA, 1);
    waitCycle();
    waitDrain(0, 5000);
    waitDone(0, 20);
    @(negedge clk_41);
    checkOutput("roundtrip count", countA, 10000);
    checkOutput("roundtrip busy", busyA, 0);
    waitCycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addr_trace_encoder.md
# addr_trace_encoder

Hardware capture block that converts a stream of absolute 31-bit cache request addresses into the delta-encoded trace format consumed by the cache simulation bench. The first record after arming is the absolute address; every following record is the signed difference from the previous address, modulo 2^31. Records are buffered in a small FIFO behind a valid/ready handshake, so a downstream trace writer can stall without losing addresses. The block sits on the cache request bus, in parallel with the cache model, and produces `addr_trace.txt`-compatible records.

## Interface
- ADDR_W, 31, address and delta width; arithmetic is modulo 2^ADDR_W
- DEPTH, 4, output FIFO depth; must be a power of 2 and at least 2
- MAX_SAMPLES, 1500000, number of addresses captured per run

- clk_41  in  1  clock, rising edge
- rst_41  in  1  synchronous reset, active-low
- start_41  in  1  single-cycle arm pulse
- addr_valid_41  in  1  address offered
- addr_ready_41  out  1  address accepted when valid and ready are both high
- addr_41  in  ADDR_W  absolute address
- delta_valid_41  out  1  record available
- delta_ready_41  in  1  consumer takes the record when valid and ready are both high
- delta_41  out  ADDR_W  signed record (absolute value for the first record)
- first_41  out  1  marks the record at the FIFO head as the absolute record
- count_41  out  ADDR_W  addresses accepted in the current run
- busy_41  out  1  state is RUN or DRAIN
- done_41  out  1  state is DONE

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
- **IDLE:**
  - addr_ready_41=0.
  - start_41 moves the FSM to RUN, clears prev_addr and count_41, and sets the first flag.
- **RUN:**
  - addr_ready_41 = !fifo_full. It is registered and does not depend on delta_ready_41.
  - On each accepted address, push {first, addr_41 − prev_addr}, then set prev_addr←addr_41, count_41+1 and first←0.
  - The first record's delta equals addr_41 itself, because prev_addr is 0.
  - When count_41 reaches MAX_SAMPLES, go to DRAIN. addr_ready_41 drops in the same cycle.
- **DRAIN:** addr_ready_41=0. When the FIFO is empty, go to DONE.
- **DONE:**
  - done_41=1. The FIFO is empty and count_41 holds its value.
  - start_41 re-arms the block (go to RUN, as from IDLE).
- start_41 is ignored in RUN and DRAIN.
- **Arithmetic:** subtraction is ADDR_W bits wide and wraps. A decoder that accumulates in ADDR_W bits, actual[i] = actual[i−1] + delta[i], reproduces the input exactly. No overflow condition exists.
- **FIFO:**
  - Simultaneous push and pop is allowed when the FIFO is not empty, and occupancy is unchanged.
  - A push into an empty FIFO is visible on the outputs the next cycle; there is no combinational fall-through.
  - When delta_valid_41=0, delta_41 and first_41 hold their last values.

## Timing
- **Reset values (rst_41 low at a rising edge):**
  - State is IDLE.
  - addr_ready_41, delta_valid_41, first_41, busy_41 and done_41 are 0.
  - delta_41, count_41 and prev_addr are 0.
  - The FIFO is emptied.
- Reset mid-run discards any buffered records.
- **Latency:** an address accepted at edge N gives delta_valid_41=1 after edge N, when the FIFO was empty.
- addr_ready_41 first rises on the edge after start_41 is sampled.
- **Full FIFO:**
  - When occupancy reaches DEPTH at an edge, addr_ready_41 is 0 for the next cycle.
  - It returns to 1 the cycle after a pop leaves free space.
  - Accepting at most DEPTH records and then stopping is allowed.
- Sustained throughput is one record per cycle while delta_ready_41 is held high.
- busy_41 and done_41 are decoded from registered state.

## Structure
- A shared package `trace_pkg` holds:
  - ADDR_W;
  - the FSM state enum (IDLE, RUN, DRAIN, DONE);
  - the record struct {first, delta}, which the bench-side decoder and the trace writer also use.
- One sub-module, `trace_fifo`, is a synchronous FIFO:
  - width ADDR_W+1, depth DEPTH;
  - outputs full and empty;
  - registered head outputs.
- The FSM, prev_addr and the counter live in the top module.

## Test plan
- **Basic encode:** start, then addresses 100, 104, 96, 2147483647, 0 with consumer always ready → records (first=1, 100), 4, −8, 2147483551, 1 (mod 2^31); count_41=5.
- **Round trip:** 10000 random addresses, with MAX_SAMPLES overridden to 10000, through a bench accumulator decoder → exact match with the input; done_41=1 once the FIFO has drained.
- **Backpressure:** delta_ready_41=0 while addresses are offered every cycle → exactly DEPTH=4 accepted, addr_ready_41=0 the next cycle; release → in-order delivery and no loss.
- **Simultaneous push and pop:** occupancy 2 with valid and ready high on both sides for 20 cycles → occupancy stays 2 and output order is preserved.
- **Terminal count:** MAX_SAMPLES=3 with 5 addresses offered → 3 accepted, DRAIN, then DONE; start_41 → count_41=0 and the next record has first_41=1.
- **Reset mid-run:** rst_41 low while 3 records are buffered → next cycle all outputs are at reset values and no stale record appears after re-arming.
